// File: rtl/tile_map_ctrl.sv
// Tile-map BRAM port owner: arbitrates video reads, game-logic req/ack accesses and a fill sequencer.
// Optional macro TILE_MAP_BOUNDS_CHECK_EN adds out-of-range checking for host and video coordinates.
module tile_map_ctrl #(
  parameter int COLS   = 20,
  parameter int ROWS   = 15,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Vid_Active,
  input  logic [4:0]        i_Vid_Cell_X,
  input  logic [3:0]        i_Vid_Cell_Y,
  output logic [DATA_W-1:0] o_Vid_Tile,
  input  logic              i_Host_Req,
  input  logic              i_Host_We,
  input  logic [4:0]        i_Host_X,
  input  logic [3:0]        i_Host_Y,
  input  logic [DATA_W-1:0] i_Host_Wdata,
  output logic              o_Host_Ack,
  output logic [DATA_W-1:0] o_Host_Rdata,
  output logic              o_Host_Err,
  input  logic              i_Clear_Start,
  input  logic [DATA_W-1:0] i_Clear_Value,
  output logic              o_Busy,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [DATA_W-1:0] o_Mem_Wdata,
  output logic              o_Mem_We,
  input  logic [DATA_W-1:0] i_Mem_Rdata
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, H_RD_WAIT, H_RD_CAP} state_t;

  state_t              state_r;
  logic                rst_meta_r;
  logic                rst_sync_r;
  logic [ADDR_W-1:0]   clr_cnt_r;
  logic [DATA_W-1:0]   clr_val_r;
  logic                wr_pend_r;
  logic                vid_v1_r;
  logic                vid_v2_r;
  logic                vid_oob1_r;
  logic                vid_oob2_r;
  logic [ADDR_W-1:0]   vid_addr_s;
  logic [ADDR_W-1:0]   host_addr_s;
  logic                vid_oob_s;
  logic                host_oob_s;
  logic                host_grant_s;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] y, input logic [4:0] x);
    logic [ADDR_W+8:0] full;
    full = (ADDR_W+9)'(y) * (ADDR_W+9)'(COLS) + (ADDR_W+9)'(x);
    return full[ADDR_W-1:0];
  endfunction

  // Address decode, range flags and host grant qualification
  always_comb begin
    vid_addr_s  = cell_addr(i_Vid_Cell_Y, i_Vid_Cell_X);
    host_addr_s = cell_addr(i_Host_Y, i_Host_X);
`ifdef TILE_MAP_BOUNDS_CHECK_EN
    vid_oob_s   = ({1'b0, i_Vid_Cell_X} >= 6'(COLS)) || ({1'b0, i_Vid_Cell_Y} >= 5'(ROWS));
    host_oob_s  = ({1'b0, i_Host_X} >= 6'(COLS)) || ({1'b0, i_Host_Y} >= 5'(ROWS));
`else
    vid_oob_s   = 1'b0;
    host_oob_s  = 1'b0;
`endif
    // A pending write ack or a visible ack blocks re-sampling of the still-held request
    host_grant_s = (state_r == IDLE) && i_Host_Req && !i_Vid_Active && !i_Clear_Start
                   && !wr_pend_r && !o_Host_Ack;
  end

  // Reset synchronizer: asynchronous assert, synchronous release
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  // Fixed three-cycle video read pipe
  always_ff @(posedge i_Clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      vid_v1_r   <= 1'b0;
      vid_v2_r   <= 1'b0;
      vid_oob1_r <= 1'b0;
      vid_oob2_r <= 1'b0;
      o_Vid_Tile <= {DATA_W{1'b0}};
    end else begin
      vid_v1_r   <= i_Vid_Active;
      vid_oob1_r <= i_Vid_Active & vid_oob_s;
      vid_v2_r   <= vid_v1_r;
      vid_oob2_r <= vid_oob1_r;
      if (vid_v2_r) begin
        o_Vid_Tile <= vid_oob2_r ? {DATA_W{1'b0}} : i_Mem_Rdata;
      end
    end
  end

  // Memory slot arbitration and control FSM
  always_ff @(posedge i_Clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      state_r      <= IDLE;
      clr_cnt_r    <= {ADDR_W{1'b0}};
      clr_val_r    <= {DATA_W{1'b0}};
      wr_pend_r    <= 1'b0;
      o_Busy       <= 1'b0;
      o_Host_Ack   <= 1'b0;
      o_Host_Err   <= 1'b0;
      o_Host_Rdata <= {DATA_W{1'b0}};
      o_Mem_Addr   <= {ADDR_W{1'b0}};
      o_Mem_Wdata  <= {DATA_W{1'b0}};
      o_Mem_We     <= 1'b0;
    end else begin
      o_Mem_We   <= 1'b0;
      o_Host_Ack <= wr_pend_r;
      o_Host_Err <= 1'b0;
      wr_pend_r  <= 1'b0;

      if (i_Vid_Active) begin
        o_Mem_Addr <= vid_addr_s;
      end else if (state_r == CLEAR) begin
        o_Mem_Addr  <= clr_cnt_r;
        o_Mem_Wdata <= clr_val_r;
        o_Mem_We    <= 1'b1;
      end else if (host_grant_s && !host_oob_s) begin
        o_Mem_Addr <= host_addr_s;
        o_Mem_We   <= i_Host_We;
        if (i_Host_We) begin
          o_Mem_Wdata <= i_Host_Wdata;
        end
      end

      case (state_r)
        IDLE: begin
          if (i_Clear_Start) begin
            clr_val_r <= i_Clear_Value;
            clr_cnt_r <= {ADDR_W{1'b0}};
            o_Busy    <= 1'b1;
            state_r   <= CLEAR;
          end else if (host_grant_s) begin
            if (host_oob_s) begin
              o_Host_Ack   <= 1'b1;
              o_Host_Err   <= 1'b1;
              o_Host_Rdata <= {DATA_W{1'b0}};
            end else if (i_Host_We) begin
              wr_pend_r <= 1'b1;
            end else begin
              state_r <= H_RD_WAIT;
            end
          end
        end
        CLEAR: begin
          // Video slots stall the sweep without advancing the counter
          if (!i_Vid_Active) begin
            if (clr_cnt_r == LAST_CELL) begin
              o_Busy  <= 1'b0;
              state_r <= IDLE;
            end else begin
              clr_cnt_r <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        H_RD_WAIT: begin
          state_r <= H_RD_CAP;
        end
        H_RD_CAP: begin
          o_Host_Rdata <= i_Mem_Rdata;
          o_Host_Ack   <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tile_map_ctrl.md
Name: tile_map_ctrl

Overview:
Owns the single memory port of the 4-bit tile-map BRAM (COLS x ROWS cells, row-major) and arbitrates it between three users. The users are the VGA renderer (fixed-latency reads during active video), the game logic (req/ack reads and writes) and a built-in clear sequencer that fills the whole map with one value. It sits between the VGA timing/cell counters, the game-logic FSM and the SB_RAM40_4K instance.

Parameters:
COLS, 20, tiles per row
ROWS, 15, tile rows
ADDR_W, 10, BRAM address width
DATA_W, 4, bits per tile

Ports:
i_Clk  in  1  system clock; only clock
i_Rst_n  in  1  asynchronous, active-low reset
i_Vid_Active  in  1  renderer owns the next memory slot
i_Vid_Cell_X  in  5  renderer tile column
i_Vid_Cell_Y  in  4  renderer tile row
o_Vid_Tile  out  DATA_W  tile for the coordinates sampled 3 cycles earlier
i_Host_Req  in  1  game-logic request; level, held until ack
i_Host_We  in  1  1 = write, 0 = read
i_Host_X  in  5  host tile column
i_Host_Y  in  4  host tile row
i_Host_Wdata  in  DATA_W  host write data
o_Host_Ack  out  1  one-cycle completion pulse
o_Host_Rdata  out  DATA_W  read result; valid with ack
o_Host_Err  out  1  out-of-range pulse (see Optional Feature)
i_Clear_Start  in  1  pulse: fill map with i_Clear_Value
i_Clear_Value  in  DATA_W  fill value, latched on start
o_Busy  out  1  clear in progress
o_Mem_Addr  out  ADDR_W  BRAM address (registered)
o_Mem_Wdata  out  DATA_W  BRAM write data (registered)
o_Mem_We  out  1  BRAM write enable (registered)
i_Mem_Rdata  in  DATA_W  BRAM read data; 1-cycle latency after address

Behaviour:
- Reset: all outputs are 0. The FSM goes to IDLE. Async assert, sync release.
- Address is y*COLS+x, truncated to ADDR_W. CELLS = COLS*ROWS = 300.
- Slot arbitration at each edge, strict priority:
  - Video, when i_Vid_Active=1.
  - Clear sequencer, when state is CLEAR.
  - Host, when state is IDLE and i_Host_Req=1.
  - Otherwise no slot: o_Mem_We=0 and the address holds.
- o_Mem_We is never 1 in a video-owned slot.
- Video pipe:
  - Coordinates sampled at edge N drive o_Mem_Addr in cycle N+1.
  - i_Mem_Rdata is valid in cycle N+2 and is registered into o_Vid_Tile, valid in cycle N+3.
  - Latency is fixed at 3, independent of host or clear activity.
  - o_Vid_Tile holds its value when no video read is in flight.
- FSM states: IDLE, CLEAR, H_RD_WAIT, H_RD_CAP.
  - IDLE + i_Clear_Start: latch the value, go to CLEAR, set counter = 0, o_Busy=1 from the next cycle. Clear wins over a simultaneous host request.
  - IDLE + host granted, write: issue the write slot (o_Mem_We=1). o_Host_Ack pulses in the cycle after the slot. Stay in IDLE.
  - IDLE + host granted, read: issue the read slot and go to H_RD_WAIT. Then go to H_RD_CAP, which latches i_Mem_Rdata into o_Host_Rdata and pulses ack. Then return to IDLE.
  - Once a host access is issued, later video slots do not disturb it.
  - Host is never granted while i_Vid_Active=1 or while in CLEAR. The request waits indefinitely with no timeout.
  - The new request is sampled one cycle after ack, so a back-to-back request is legal.
  - CLEAR: write the latched value to counter 0..CELLS-1, in order, one per non-video slot. Video slots pause the sweep without skipping addresses.
  - After the slot for CELLS-1, go to IDLE with o_Busy=0.
  - i_Clear_Start while busy is ignored.
- Reset mid-operation aborts everything and drops any pending ack. The map is left partially written. No recovery is attempted.

Optional Feature:
- Macro TILE_MAP_BOUNDS_CHECK_EN.
- Defined:
  - A host request with x>=COLS or y>=ROWS takes no memory slot.
  - o_Host_Ack and o_Host_Err pulse together, the cycle after grant, with o_Host_Rdata=0.
  - Video coordinates out of range yield o_Vid_Tile=0 at the normal latency.
- Undefined: o_Host_Err is tied 0. Addresses are computed and truncated with no checking.

Test Plan:
1. Reset: assert i_Rst_n=0 mid-clear -> all outputs 0 immediately; after release, o_Busy=0 and a host write to (0,0) is acked normally.
2. Video latency: mem[43]=5, i_Vid_Active=1, cell (3,2) at edge N -> o_Mem_Addr=43 in cycle N+1, o_Vid_Tile=5 in cycle N+3.
3. Host write blocked: hold write (10,7)=9 with i_Vid_Active=1 for 50 cycles -> no ack and o_Mem_We=0 throughout. Drop i_Vid_Active -> addr 150 with We=1 and data 9, then a 1-cycle ack. A following read of (10,7) -> ack with o_Host_Rdata=9.
4. Clear: start with value 1 while i_Vid_Active toggles 8 on / 8 off -> exactly 300 writes to addresses 0..299 in order, none in video slots. o_Busy falls after addr 299. A host request pending during the clear is acked only afterwards.
5. Simultaneous i_Clear_Start and host write in IDLE -> clear runs first; the host write to addr X lands after the 300 clear writes, so mem[X] = host data.
6. Bounds: with the macro, host write (20,0) -> ack+err, no We. Without the macro -> We at addr 20 and o_Host_Err=0.
